// File: rtl/prng_arbiter_pkg.sv
// Shared types, constants and the xorshift16 step for the PRNG arbiter.
package prng_arbiter_pkg;

  typedef logic [15:0] rand_t;

  localparam rand_t DEFAULT_SEED = 16'h5A3C;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  function automatic rand_t xorshift16_step(input rand_t x);
    rand_t t;
    t = x ^ (x << 7);
    t = t ^ (t >> 9);
    t = t ^ (t << 8);
    return t;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_select #(
  parameter int NUM_REQ = 4,
  parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic               valid_o
);

  logic [PW-1:0] idx;

  always_comb begin
    win_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = PW'((32'(ptr_i) + i) % NUM_REQ);
      if (!valid_o && req_i[idx]) begin
        win_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prng_arbiter.sv
// Round-robin arbiter handing out xorshift16 words, one grant per cycle.
// Optional grant counter enabled by defining PRNG_ARBITER_STATS_EN.
module prng_arbiter
  import prng_arbiter_pkg::*;
#(
  parameter int    NUM_REQ = 4,
  parameter rand_t SEED    = DEFAULT_SEED
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [15:0]        rand_data,
  input  logic               reseed,
  input  logic [15:0]        reseed_value
`ifdef PRNG_ARBITER_STATS_EN
  ,output logic [31:0]       grant_count
`endif
);

  localparam int PW = $clog2(NUM_REQ);

  rand_t              x_q;
  rand_t              x_step;
  rand_t              rand_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [PW-1:0]      ptr_q, ptr_d;
  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] win;
  logic               win_valid;
  logic [PW-1:0]      widx;
  logic               grant_go;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr_select (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .win_o   (win),
    .valid_o (win_valid)
  );

  // state_d is the mode of the current cycle; grants only issue in RUN.
  always_comb begin
    state_d = ST_RUN;
    case (state_q)
      ST_LOAD: state_d = enable ? ST_RUN : ST_HOLD;
      ST_HOLD: state_d = enable ? ST_RUN : ST_HOLD;
      default: state_d = enable ? ST_RUN : ST_HOLD;
    endcase
    if (reseed) state_d = ST_LOAD;
  end

  always_comb begin
    widx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win[i]) widx = PW'(i);
    end
    ptr_d = (widx == PW'(NUM_REQ - 1)) ? '0 : widx + 1'b1;
  end

  assign grant_go = (state_d == ST_RUN) && win_valid;
  assign x_step   = xorshift16_step(x_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= SEED;
      gnt_q   <= '0;
      rand_q  <= '0;
      ptr_q   <= '0;
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
      gnt_q   <= grant_go ? win : '0;
      if (reseed) begin
        x_q <= (reseed_value == 16'h0000) ? SEED : reseed_value;
      end else if (grant_go) begin
        x_q    <= x_step;
        rand_q <= x_step;
        ptr_q  <= ptr_d;
      end
    end
  end

  assign gnt       = gnt_q;
  assign rand_data = rand_q;

`ifdef PRNG_ARBITER_STATS_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (grant_go && cnt_q != '1) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign grant_count = cnt_q;
`endif

endmodule

// File: tb/tb_prng_arbiter.sv
// Directed self-checking bench for prng_arbiter (NUM_REQ=4, default SEED).
module tb_prng_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [15:0] rand_data;
  logic        reseed;
  logic [15:0] reseed_value;
`ifdef PRNG_ARBITER_STATS_EN
  logic [31:0] grant_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prng_arbiter #(
    .NUM_REQ (4),
    .SEED    (16'h5A3C)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .req          (req),
    .gnt          (gnt),
    .rand_data    (rand_data),
    .reseed       (reseed),
    .reseed_value (reseed_value)
`ifdef PRNG_ARBITER_STATS_EN
    ,.grant_count (grant_count)
`endif
  );

  // Independent bit-concatenation form of the xorshift step.
  function automatic logic [15:0] ref_step(input logic [15:0] x);
    logic [15:0] a;
    a = x ^ {x[8:0], 7'b0};
    a = a ^ {9'b0, a[15:9]};
    a = a ^ {a[7:0], 8'b0};
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b1; req = 4'b0; reseed = 1'b0; reseed_value = 16'h0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1; req = 4'b1111;
    tick();
    checks++;
    if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt got=%h exp=%h", gnt, 4'b0); end
    checks++;
    if (rand_data !== 16'h0) begin errors++; $display("FAIL reset_rand got=%h exp=%h", rand_data, 16'h0); end
    rst = 1'b0; req = 4'b0;
  endtask

  task automatic test_single();
    logic [15:0] exp_x, prev;
    do_reset();
    req = 4'b0001;
    tick();
    checks++;
    if (gnt !== 4'b0001 || rand_data !== 16'h5A1E) begin
      errors++; $display("FAIL single_first gnt=%b rand=%h exp gnt=0001 rand=5a1e", gnt, rand_data);
    end
    tick();
    checks++;
    if (gnt !== 4'b0001 || rand_data !== 16'h6134) begin
      errors++; $display("FAIL single_second gnt=%b rand=%h exp gnt=0001 rand=6134", gnt, rand_data);
    end
    exp_x = 16'h6134;
    for (int i = 0; i < 4; i++) begin
      prev  = exp_x;
      exp_x = ref_step(exp_x);
      tick();
      checks++;
      if (gnt !== 4'b0001 || rand_data !== exp_x || rand_data == prev || rand_data == 16'h0) begin
        errors++; $display("FAIL single_stream[%0d] gnt=%b rand=%h exp gnt=0001 rand=%h", i, gnt, rand_data, exp_x);
      end
    end
    req = 4'b0;
    tick();
    checks++;
    if (gnt !== 4'b0 || rand_data !== exp_x) begin
      errors++; $display("FAIL idle_hold gnt=%b rand=%h exp gnt=0000 rand=%h", gnt, rand_data, exp_x);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0]  order [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [3:0]  sparse [3] = '{4'b0010, 4'b1000, 4'b0010};
    logic [15:0] exp_x;
    do_reset();
    req   = 4'b1111;
    exp_x = 16'h5A3C;
    for (int i = 0; i < 6; i++) begin
      exp_x = ref_step(exp_x);
      tick();
      checks++;
      if (gnt !== order[i] || rand_data !== exp_x) begin
        errors++; $display("FAIL rr_all[%0d] gnt=%b rand=%h exp gnt=%b rand=%h", i, gnt, rand_data, order[i], exp_x);
      end
    end
    do_reset();
    req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (gnt !== sparse[i]) begin
        errors++; $display("FAIL rr_sparse[%0d] gnt=%b exp=%b", i, gnt, sparse[i]);
      end
    end
  endtask

  task automatic test_reseed();
    do_reset();
    req = 4'b0100;
    tick();
    reseed = 1'b1; reseed_value = 16'h0000;
    tick();
    checks++;
    if (gnt !== 4'b0 || rand_data !== 16'h5A1E) begin
      errors++; $display("FAIL reseed_zero_cycle gnt=%b rand=%h exp gnt=0000 rand=5a1e", gnt, rand_data);
    end
    reseed = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0100 || rand_data !== 16'h5A1E) begin
      errors++; $display("FAIL reseed_zero_next gnt=%b rand=%h exp gnt=0100 rand=5a1e", gnt, rand_data);
    end
    reseed = 1'b1; reseed_value = 16'h1234;
    tick();
    reseed = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0100 || rand_data !== 16'h3830) begin
      errors++; $display("FAIL reseed_value gnt=%b rand=%h exp gnt=0100 rand=3830", gnt, rand_data);
    end
    // Pointer must survive a reseed: grant 0, reseed, then grant 1.
    do_reset();
    req = 4'b1111;
    tick();
    reseed = 1'b1; reseed_value = 16'h1234;
    tick();
    reseed = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0010 || rand_data !== 16'h3830) begin
      errors++; $display("FAIL reseed_ptr gnt=%b rand=%h exp gnt=0010 rand=3830", gnt, rand_data);
    end
  endtask

  task automatic test_enable();
    do_reset();
    req = 4'b0010; enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (gnt !== 4'b0 || rand_data !== 16'h0) begin
        errors++; $display("FAIL enable_low[%0d] gnt=%b rand=%h exp gnt=0000 rand=0000", i, gnt, rand_data);
      end
    end
    enable = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0010 || rand_data !== 16'h5A1E) begin
      errors++; $display("FAIL enable_resume gnt=%b rand=%h exp gnt=0010 rand=5a1e", gnt, rand_data);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    req = 4'b1111;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0 || rand_data !== 16'h0) begin
      errors++; $display("FAIL rst_mid_cycle gnt=%b rand=%h exp gnt=0000 rand=0000", gnt, rand_data);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0001 || rand_data !== 16'h5A1E) begin
      errors++; $display("FAIL rst_mid_after gnt=%b rand=%h exp gnt=0001 rand=5a1e", gnt, rand_data);
    end
  endtask

`ifdef PRNG_ARBITER_STATS_EN
  task automatic test_stats();
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 10; i++) tick();
    req = 4'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (grant_count !== 32'd10) begin
      errors++; $display("FAIL stats_count got=%0d exp=10", grant_count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (grant_count !== 32'd0) begin
      errors++; $display("FAIL stats_clear got=%0d exp=0", grant_count);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; enable = 1'b1; req = 4'b0; reseed = 1'b0; reseed_value = 16'h0;
    test_reset();
    test_single();
    test_round_robin();
    test_reseed();
    test_enable();
    test_rst_mid();
`ifdef PRNG_ARBITER_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prng_arbiter.md
PRNG_ARBITER -- requirements
Module: prng_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter SEED, default 16'h5A3C, generator state loaded at reset (zero not permitted).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port enable  input  1  global run enable; low freezes grants and generator.
REQ-006 SHALL have port req  input  NUM_REQ  per-requester level request for one random word.
REQ-007 SHALL have port gnt  output  NUM_REQ  registered one-hot grant, one-cycle pulse.
REQ-008 SHALL have port rand_data  output  16  random word, valid only in the cycle gnt is nonzero.
REQ-009 SHALL have port reseed  input  1  one-cycle pulse to load a new generator state.
REQ-010 SHALL have port reseed_value  input  16  state loaded on reseed.

Function
REQ-011 SHALL hold a 16-bit xorshift state x; step = x^=x<<7, then x^=x>>9, then x^=x<<8 (16-bit truncation each stage).
REQ-012 SHALL advance the state only in a cycle that issues a grant; state held otherwise.
REQ-013 In a granting cycle, gnt and rand_data SHALL both update on the next edge, with rand_data = step(x) and x <= step(x).
REQ-014 Latency: req[i] high at edge N with no reseed, enable high, no competing winner -> gnt[i] high after edge N+1.
REQ-015 SHALL grant at most one requester per cycle; a requester held high while alone SHALL be granted every cycle.
REQ-016 Arbitration SHALL be round-robin: search starts at (last granted index + 1) mod NUM_REQ; pointer updates only on grant.
REQ-017 A requester SHALL hold req until it sees gnt; dropping req earlier withdraws it with no grant and no state advance.
REQ-018 FSM states: RUN (granting), HOLD (enable low), LOAD (reseed cycle); reseed from any state -> LOAD for one cycle -> RUN if enable else HOLD.
REQ-019 reseed SHALL take priority over arbitration: no grant in that cycle, pointer unchanged, x <= reseed_value.
REQ-020 reseed_value of 0 SHALL load SEED instead (zero is the xorshift lock-up state).
REQ-021 enable low SHALL force gnt to zero and freeze x and pointer; reseed is still honoured.
REQ-022 gnt SHALL be zero whenever no requester is eligible; rand_data holds its last value.

Reset
REQ-023 rst SHALL set x=SEED, gnt=0, rand_data=0, pointer=0, FSM=RUN; rst dominates reseed and enable.
REQ-024 rst asserted mid-operation SHALL drop any grant that would issue that cycle; requests pending after release re-arbitrate from index 0.

Configuration
REQ-025 With macro PRNG_ARBITER_STATS_EN defined, SHALL add output grant_count (32 bits): grants since reset, saturating at 2^32-1, cleared by rst, unaffected by reseed.
REQ-026 Without PRNG_ARBITER_STATS_EN, grant_count port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-027 Package prng_arbiter_pkg SHALL hold rand_t (16-bit) typedef, DEFAULT_SEED constant, FSM state enum, and the xorshift16_step function.
REQ-028 Round-robin selection SHALL be a sub-module rr_select (req vector + pointer in, one-hot winner + valid out, combinational).

Verification
REQ-029 Reset, SEED=16'h5A3C, hold req[0] only -> gnt[0] on next cycle with rand_data 16'h5A1E, then a grant every cycle with differing nonzero data.
REQ-030 NUM_REQ=4, all req held -> grant order 0,1,2,3,0,1 on consecutive cycles, no gaps, no double grants.
REQ-031 reseed with reseed_value 0 during continuous req[2] -> no grant that cycle; next grant rand_data 16'h5A1E.
REQ-032 enable low 5 cycles with req[1] high -> gnt stays 0 and state frozen; enable high -> gnt[1] one cycle later.
REQ-033 rst pulse mid-stream with all req high -> gnt 0 in reset cycle; after release first grant to index 0 with rand_data 16'h5A1E.
REQ-034 PRNG_ARBITER_STATS_EN defined, 10 grants then 3 idle cycles -> grant_count 10; rst -> 0.
